// File: rtl/fetch_stage.sv
// RISC-V instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, and fills the IF/ID register under decode stall and execute redirect.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [4:0]      if_id_opcode
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MSK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic [XLEN-1:0] hold_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;

  logic [XLEN-1:0] redir_tgt;
  logic            slot_free;
  logic [XLEN-1:0] pc_next_seq;

  assign redir_tgt   = redirect_pc & ALIGN_MSK;
  assign slot_free   = !if_valid_q || !stall;
  assign pc_next_seq = pc_q + PC_STEP;

  // Fetch FSM plus IF/ID register; a later load in the case overrides the default valid clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      hold_q     <= {XLEN{1'b0}};
      if_valid_q <= 1'b0;
      if_pc_q    <= {XLEN{1'b0}};
      if_instr_q <= NOP_INSTR;
    end else begin
      if (redirect_valid || !stall || !if_valid_q) begin
        if_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          if (redirect_valid) begin
            pc_q <= redir_tgt;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc_q <= redir_tgt;
          end else if (imem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_q <= redir_tgt;
            if (imem_rsp_valid) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            state_q <= S_REQ;
            if (drop_q) begin
              drop_q <= 1'b0;
            end else if (slot_free) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_instr_q <= imem_rsp_data;
              pc_q       <= pc_next_seq;
            end else begin
              hold_q  <= imem_rsp_data;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // The parked word belongs to pc_q, which only advances once it reaches IF/ID.
          if (redirect_valid) begin
            pc_q    <= redir_tgt;
            state_q <= S_REQ;
          end else if (!stall) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_q;
            if_instr_q <= hold_q;
            pc_q       <= pc_next_seq;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_addr      = pc_q;
  assign if_id_valid    = if_valid_q;
  assign if_id_pc       = if_pc_q;
  assign if_id_instr    = if_instr_q;
  assign if_id_opcode   = if_instr_q[6:2];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a slot/park transaction model plus an
// instruction-memory responder, with directed scenarios and literal checkpoints.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [4:0]  if_id_opcode;

  logic        w_req_valid;
  logic [31:0] w_addr;
  logic        w_if_id_valid;
  logic [31:0] w_if_id_pc;
  logic [31:0] w_if_id_instr;
  logic [4:0]  w_if_id_opcode;

  fetch_stage u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_opcode(if_id_opcode)
  );

  // Same stimulus, wrapping reset PC: timing is PC-independent, so it stays in lockstep.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(w_if_id_valid), .if_id_pc(w_if_id_pc), .if_id_instr(w_if_id_instr),
    .if_id_opcode(w_if_id_opcode)
  );

  int checks = 0;
  int errors = 0;

  // Model state: expected IF/ID slot, parked word, outstanding request, next fetch PC.
  logic        m_started;
  logic        m_busy;
  int          m_wait;
  logic [31:0] m_out_addr;
  logic        m_drop;
  logic        m_slot_v;
  logic [31:0] m_slot_pc;
  logic [31:0] m_slot_instr;
  logic        m_park_v;
  logic [31:0] m_park_pc;
  logic [31:0] m_park_instr;
  logic [31:0] m_next_pc;
  int          mem_lat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[21:0], a[6:2], 5'b10011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_started    = 1'b0;
    m_busy       = 1'b0;
    m_wait       = 0;
    m_out_addr   = 32'h0;
    m_drop       = 1'b0;
    m_slot_v     = 1'b0;
    m_slot_pc    = 32'h0;
    m_slot_instr = 32'h0000_0013;
    m_park_v     = 1'b0;
    m_park_pc    = 32'h0;
    m_park_instr = 32'h0;
    m_next_pc    = 32'h0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must be at reset values at once.
  task automatic apply_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    #1;
    chk("rst_if_id_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_if_id_pc", if_id_pc, 32'h0);
    chk("rst_if_id_instr", if_id_instr, 32'h0000_0013);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive memory response, check request side, advance model, check IF/ID.
  task automatic cycle();
    logic rsp_now;
    logic exp_req;
    logic acc;
    logic loaded;
    rsp_now = 1'b0;
    if (m_busy) begin
      m_wait--;
      if (m_wait == 0) rsp_now = 1'b1;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(m_out_addr) : 32'h0;
    #1;
    exp_req = m_started && !m_busy && !m_park_v && !redirect_valid;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, m_next_pc);
    acc = exp_req && imem_req_ready;
    loaded = 1'b0;
    if (rsp_now) m_busy = 1'b0;
    if (redirect_valid) begin
      m_slot_v  = 1'b0;
      m_park_v  = 1'b0;
      m_next_pc = {redirect_pc[31:2], 2'b00};
      m_drop    = m_busy;
    end else begin
      if (rsp_now) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else if (!m_slot_v || !stall) begin
          m_slot_v = 1'b1; m_slot_pc = m_out_addr; m_slot_instr = imem_rsp_data;
          m_next_pc = m_out_addr + 32'd4;
          loaded = 1'b1;
        end else begin
          m_park_v = 1'b1; m_park_pc = m_out_addr; m_park_instr = imem_rsp_data;
        end
      end else if (m_park_v && !stall) begin
        m_slot_v = 1'b1; m_slot_pc = m_park_pc; m_slot_instr = m_park_instr;
        m_next_pc = m_park_pc + 32'd4;
        m_park_v = 1'b0;
        loaded = 1'b1;
      end
      if (!loaded && !(m_slot_v && stall)) m_slot_v = 1'b0;
      if (acc) begin
        m_busy = 1'b1; m_out_addr = m_next_pc; m_wait = mem_lat;
      end
    end
    m_started = 1'b1;
    @(posedge clk); #1;
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_slot_v});
    chk("if_id_pc", if_id_pc, m_slot_pc);
    chk("if_id_instr", if_id_instr, m_slot_instr);
    chk("if_id_opcode", {27'b0, if_id_opcode}, {27'b0, m_slot_instr[6:2]});
  endtask

  logic [63:0] stall_pat;
  logic [63:0] redir_pat;
  logic [63:0] ready_pat;

  initial begin
    mem_lat = 1;
    apply_reset();

    // First fetch after reset, 1-cycle memory.
    cycle();
    chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_first_addr", imem_addr, 32'h0);
    cycle();
    cycle();
    chk("t1_if_id_valid", {31'b0, if_id_valid}, 32'd1);
    chk("t1_if_id_pc", if_id_pc, 32'h0);
    chk("t1_if_id_instr", if_id_instr, 32'h0050_0093);
    chk("t1_opcode", {27'b0, if_id_opcode}, 32'h0000_0004);
    chk("t1_next_addr", imem_addr, 32'h4);
    chk("t4_wrap_if_id_pc", w_if_id_pc, 32'hFFFF_FFFC);
    chk("t4_wrap_if_id_valid", {31'b0, w_if_id_valid}, 32'd1);
    chk("t4_wrap_instr", w_if_id_instr, 32'h0050_0093);
    chk("t4_wrap_opcode", {27'b0, w_if_id_opcode}, 32'h0000_0004);
    chk("t4_wrap_req_valid", {31'b0, w_req_valid}, 32'd1);
    chk("t4_wrap_next_addr", w_addr, 32'h0);

    // Stall for five cycles: second word parks, no further request.
    stall = 1'b1;
    cycle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_hold_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("t2_hold_pc", if_id_pc, 32'h0);
    end
    stall = 1'b0;
    cycle();
    chk("t2_release_pc", if_id_pc, 32'h4);
    chk("t2_release_instr", if_id_instr, 32'h0000_1033);
    chk("t2_release_next", imem_addr, 32'h8);

    // Redirect while waiting on a slow response.
    mem_lat = 3;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t3_redir_addr", imem_addr, 32'h100);
    cycle();
    cycle();
    chk("t3_req_after_drop", {31'b0, imem_req_valid}, 32'd1);
    chk("t3_dropped_valid", {31'b0, if_id_valid}, 32'd0);
    mem_lat = 1;
    cycle();
    cycle();
    chk("t3_target_pc", if_id_pc, 32'h100);
    chk("t3_target_instr", if_id_instr, 32'h0004_0013);

    // Misaligned redirect target and PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    cycle();
    chk("t4_align_addr", imem_addr, 32'h200);
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    cycle();
    chk("t4_top_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("t4_top_instr", if_id_instr, 32'hFFFF_F3F3);
    chk("t4_wrap_addr", imem_addr, 32'h0);

    // Memory not ready: request held steady.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_valid_held", {31'b0, imem_req_valid}, 32'd1);
      chk("t5_addr_held", imem_addr, 32'h0);
    end
    imem_req_ready = 1'b1;
    cycle();
    cycle();
    chk("t5_loaded_pc", if_id_pc, 32'h0);

    // Reset while waiting, then while holding a parked word.
    mem_lat = 3;
    cycle();
    apply_reset();
    mem_lat = 1;
    cycle();
    cycle();
    cycle();
    stall = 1'b1;
    cycle();
    cycle();
    chk("t6_in_hold", {31'b0, imem_req_valid}, 32'd0);
    apply_reset();

    // Mixed stall / redirect / ready patterns against the model.
    stall_pat = 64'h0F0F_3C00_00FF_1230;
    redir_pat = 64'h0100_0040_0002_0800;
    ready_pat = 64'hFFF0_FFFF_7FFF_F3FF;
    for (int i = 0; i < 192; i++) begin
      stall          = stall_pat[i % 64];
      redirect_valid = redir_pat[i % 64];
      redirect_pc    = 32'h0000_0400 + 32'(i * 8) + 32'(i % 4);
      imem_req_ready = ready_pat[i % 64];
      mem_lat        = (i % 3) + 1;
      cycle();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
